// File: rtl/freq_detector_hyst.sv
`timescale 1ns/1ps
// freq_detector_hyst
// Measures the period of a signed ADC stream in adc_clk cycles. A Schmitt
// trigger with runtime hysteresis finds rising zero crossings, 2^AVG_LOG2
// periods are averaged per result, stability is judged against a runtime
// tolerance, and loss of signal is declared on period-counter saturation.
//
// Ports
//   adc_clk      : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   data_in      : signed ADC sample, DATA_WIDTH bits
//   hyst         : unsigned hysteresis half-width, DATA_WIDTH-1 bits
//   tol          : unsigned stability tolerance in cycles
//   period       : latest averaged period in cycles
//   period_valid : one-cycle pulse when period updates
//   stable       : averaged period steady within tol
//   no_signal    : no crossing for 2^CNT_WIDTH-1 cycles
module freq_detector_hyst #(
  parameter int unsigned DATA_WIDTH    = 12,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned TOL_WIDTH     = 8
) (
  input  logic                         adc_clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic        [DATA_WIDTH-2:0] hyst,
  input  logic        [TOL_WIDTH-1:0]  tol,
  output logic        [CNT_WIDTH-1:0]  period,
  output logic                         period_valid,
  output logic                         stable,
  output logic                         no_signal
);

  localparam int unsigned ACC_W = CNT_WIDTH + AVG_LOG2;
  localparam int unsigned NS_W  = AVG_LOG2 + 1;
  localparam int unsigned MW    = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned CMP_W = (CNT_WIDTH > TOL_WIDTH) ? CNT_WIDTH : TOL_WIDTH;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [NS_W-1:0]      NSAMP_LAST = NS_W'((2 ** AVG_LOG2) - 1);
  localparam logic [MW-1:0]        MATCH_MAX  = MW'(STABLE_CYCLES);

  typedef enum logic {S_UNARMED, S_ARMED} arm_t;

  arm_t                   state_q, state_d;
  logic                   sch_q, sch_d, sch_prev_q;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]       sum_q, sum_d;
  logic [NS_W-1:0]        nsamp_q, nsamp_d;
  logic [MW-1:0]          match_q, match_d;
  logic [CNT_WIDTH-1:0]   prev_q, prev_d;
  logic                   first_q, first_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   stable_q, stable_d;
  logic                   nosig_q, nosig_d;

  logic signed [DATA_WIDTH:0] data_ext, hyst_pos, hyst_neg;
  logic                       edge_p, cnt_at_max, within_tol;
  logic [CNT_WIDTH-1:0]       sample, avg, diff;
  logic [ACC_W-1:0]           sum_total;

  assign data_ext = {data_in[DATA_WIDTH-1], data_in};
  assign hyst_pos = {2'b00, hyst};
  assign hyst_neg = -hyst_pos;

  assign edge_p     = sch_q & ~sch_prev_q;
  assign cnt_at_max = (cnt_q == CNT_MAX);
  // Edge coinciding with saturation reports the saturated count, not a wrap.
  assign sample     = cnt_at_max ? CNT_MAX : cnt_q + 1'b1;
  assign sum_total  = sum_q + ACC_W'(sample);
  assign avg        = CNT_WIDTH'(sum_total >> AVG_LOG2);
  assign diff       = (avg >= prev_q) ? avg - prev_q : prev_q - avg;
  assign within_tol = (CMP_W'(diff) <= CMP_W'(tol));

  always_comb begin
    sch_d    = sch_q;
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    sum_d    = sum_q;
    nsamp_d  = nsamp_q;
    match_d  = match_q;
    prev_d   = prev_q;
    first_d  = first_q;
    period_d = period_q;
    valid_d  = 1'b0;
    nosig_d  = nosig_q;

    if (data_ext > hyst_pos)      sch_d = 1'b1;
    else if (data_ext < hyst_neg) sch_d = 1'b0;

    if (edge_p) begin
      cnt_d = '0;
      if (state_q == S_UNARMED) begin
        state_d = S_ARMED;
        nosig_d = 1'b0;
        first_d = 1'b1;
      end else if (nsamp_q == NSAMP_LAST) begin
        period_d = avg;
        valid_d  = 1'b1;
        sum_d    = '0;
        nsamp_d  = '0;
        prev_d   = avg;
        first_d  = 1'b0;
        if (first_q)                 match_d = '0;
        else if (!within_tol)        match_d = '0;
        else if (match_q != MATCH_MAX) match_d = match_q + 1'b1;
      end else begin
        sum_d   = sum_total;
        nsamp_d = nsamp_q + 1'b1;
      end
    end else if (cnt_at_max) begin
      state_d = S_UNARMED;
      nosig_d = 1'b1;
      cnt_d   = '0;
      sum_d   = '0;
      nsamp_d = '0;
      match_d = '0;
    end

    stable_d = (match_d == MATCH_MAX);
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_UNARMED;
      sch_q      <= 1'b0;
      sch_prev_q <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
      nsamp_q    <= '0;
      match_q    <= '0;
      prev_q     <= '0;
      first_q    <= 1'b0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      stable_q   <= 1'b0;
      nosig_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sch_q      <= sch_d;
      sch_prev_q <= sch_q;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      nsamp_q    <= nsamp_d;
      match_q    <= match_d;
      prev_q     <= prev_d;
      first_q    <= first_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      stable_q   <= stable_d;
      nosig_q    <= nosig_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign stable       = stable_q;
  assign no_signal    = nosig_q;

endmodule

// File: tb/tb_freq_detector_hyst.sv
`timescale 1ns/1ps
// Bench for freq_detector_hyst: stimulus is applied one sample per clock,
// and an event-level model (crossing timestamps, a queue of period samples)
// predicts every output after each clock.
module tb_freq_detector_hyst;

  localparam int DW  = 12;
  localparam int CW  = 16;
  localparam int MAX = (1 << CW) - 1;

  logic                 adc_clk = 1'b0;
  logic                 rst_n;
  logic signed [DW-1:0] data_in;
  logic [DW-2:0]        hyst;
  logic [7:0]           tol;
  logic [CW-1:0]        period;
  logic                 period_valid, stable, no_signal;

  freq_detector_hyst #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .AVG_LOG2(2), .STABLE_CYCLES(3), .TOL_WIDTH(8)
  ) dut (
    .adc_clk(adc_clk), .rst_n(rst_n), .data_in(data_in), .hyst(hyst), .tol(tol),
    .period(period), .period_valid(period_valid), .stable(stable), .no_signal(no_signal)
  );

  always #5 adc_clk = ~adc_clk;

  logic [CW+2:0] act_v;
  assign act_v = {period, period_valid, stable, no_signal};

  int vecs = 0;
  int errs = 0;

  // Reference model: step index, index of last counter restart, event state.
  int       m_n = 0, m_e = 0;
  bit       m_sch, m_pend, m_armed, m_first;
  int       m_q[$];
  int       m_prev, m_match;
  logic [CW-1:0] m_period;
  bit       m_valid, m_stable, m_nosig;

  function automatic logic [CW+2:0] exp_v();
    return {m_period, m_valid, m_stable, m_nosig};
  endfunction

  function automatic int sqv(input int t, input int p, input int a);
    return (t < p / 2) ? a : -a;
  endfunction

  task automatic model_reset();
    m_sch = 0; m_pend = 0; m_armed = 0; m_first = 0;
    m_q.delete(); m_prev = 0; m_match = 0;
    m_period = '0; m_valid = 0; m_stable = 0; m_nosig = 0;
    m_e = m_n;
  endtask

  // Rising crossing seen in step n is acted on in step n+1.
  task automatic model_update(input int d);
    bit ed, ns;
    int s, sum, avg, hy, dif;
    ed = m_pend;
    hy = int'(hyst);
    m_valid = 0;
    if (d > hy)       ns = 1;
    else if (d < -hy) ns = 0;
    else              ns = m_sch;
    m_pend = ns && !m_sch;
    m_sch  = ns;
    if (ed) begin
      if (!m_armed) begin
        m_armed = 1; m_nosig = 0; m_first = 1;
      end else begin
        s = m_n - m_e;
        if (s > MAX) s = MAX;
        m_q.push_back(s);
        if (m_q.size() == 4) begin
          sum = 0;
          foreach (m_q[i]) sum += m_q[i];
          avg = sum / 4;
          dif = (avg > m_prev) ? avg - m_prev : m_prev - avg;
          if (m_first)              m_match = 0;
          else if (dif <= int'(tol)) m_match = (m_match < 3) ? m_match + 1 : 3;
          else                      m_match = 0;
          m_first  = 0;
          m_prev   = avg;
          m_period = avg[CW-1:0];
          m_valid  = 1;
          m_stable = (m_match == 3);
          m_q.delete();
        end
      end
      m_e = m_n;
    end else if (m_n - m_e == MAX + 1) begin
      m_nosig = 1; m_stable = 0; m_armed = 0; m_match = 0;
      m_q.delete();
      m_e = m_n;
    end
  endtask

  task automatic step(input int d);
    @(negedge adc_clk);
    data_in = d[DW-1:0];
    @(posedge adc_clk);
    #1;
    m_n++;
    model_update(d);
  endtask

  task automatic do_reset();
    #0.5 rst_n = 1'b0;
    #3   rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_in = '0; hyst = 11'd16; tol = 8'd2;
    model_reset();
    @(posedge adc_clk); @(posedge adc_clk); #1;
    vecs++;
    if (act_v !== exp_v()) begin
      errs++; $display("FAIL reset got=%h want=%h", act_v, exp_v());
    end
    #0.5 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_square_basic();
    hyst = 11'd16; tol = 8'd2;
    for (int p = 0; p < 18; p++)
      for (int t = 0; t < 100; t++) begin
        step(sqv(t, 100, 500));
        vecs++;
        if (act_v !== exp_v()) begin
          errs++; $display("FAIL square step=%0d got=%h want=%h", m_n, act_v, exp_v());
        end
      end
    vecs++;
    if (period !== 16'd100 || stable !== 1'b1) begin
      errs++; $display("FAIL square_final period=%0d stable=%b want 100/1", period, stable);
    end
  endtask

  task automatic test_period_change();
    for (int p = 0; p < 19; p++)
      for (int t = 0; t < 200; t++) begin
        step(sqv(t, 200, 500));
        vecs++;
        if (act_v !== exp_v()) begin
          errs++; $display("FAIL change step=%0d got=%h want=%h", m_n, act_v, exp_v());
        end
      end
    vecs++;
    if (period !== 16'd200 || stable !== 1'b1) begin
      errs++; $display("FAIL change_final period=%0d stable=%b want 200/1", period, stable);
    end
  endtask

  task automatic test_sine_glitch();
    int v, ph;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      hyst = (pass == 0) ? 11'd16 : 11'd0;
      for (int t = 0; t < 5 * 400; t++) begin
        ph = t % 400;
        v  = int'(500.0 * $sin(6.283185307179586 * real'(ph) / 400.0));
        if ((ph % 200) < 5 || (ph % 200) > 195) v += (ph % 2 == 0) ? 10 : -10;
        step(v);
        vecs++;
        if (act_v !== exp_v()) begin
          errs++; $display("FAIL sine h=%0d step=%0d got=%h want=%h", hyst, m_n, act_v, exp_v());
        end
      end
      vecs++;
      if (pass == 0 && period !== 16'd400) begin
        errs++; $display("FAIL sine_clean period=%0d want 400", period);
      end else if (pass == 1 && !(period < 16'd400)) begin
        errs++; $display("FAIL sine_nohyst period=%0d want <400", period);
      end
    end
    hyst = 11'd16;
  endtask

  task automatic test_tol_boundary();
    int p;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      tol = 8'd2;
      for (int k = 0; k < 21; k++) begin
        p = ((k / 4) % 2 == 1) ? (pass == 0 ? 102 : 103) : 100;
        for (int t = 0; t < p; t++) begin
          step(sqv(t, p, 500));
          vecs++;
          if (act_v !== exp_v()) begin
            errs++; $display("FAIL tol pass=%0d step=%0d got=%h want=%h", pass, m_n, act_v, exp_v());
          end
        end
      end
      vecs++;
      if (stable !== (pass == 0)) begin
        errs++; $display("FAIL tol_final pass=%0d stable=%b want %b", pass, stable, pass == 0);
      end
    end
  endtask

  task automatic test_random();
    int base, p, a;
    do_reset();
    hyst = 11'($urandom_range(0, 40));
    for (int b = 0; b < 5; b++) begin
      tol  = 8'($urandom_range(0, 4));
      base = $urandom_range(60, 150);
      for (int k = 0; k < 4; k++) begin
        p = base + $urandom_range(0, 2);
        a = $urandom_range(int'(hyst) + 1, 1500);
        for (int t = 0; t < p; t++) begin
          step(sqv(t, p, a));
          vecs++;
          if (act_v !== exp_v()) begin
            errs++; $display("FAIL random step=%0d got=%h want=%h", m_n, act_v, exp_v());
          end
        end
      end
    end
    step(500);
    vecs++;
    if (act_v !== exp_v()) begin
      errs++; $display("FAIL random_tail got=%h want=%h", act_v, exp_v());
    end
    hyst = 11'd16;
  endtask

  task automatic test_async_reset();
    for (int t = 0; t < 330; t++) begin
      step(sqv(t % 100, 100, 500));
      vecs++;
      if (act_v !== exp_v()) begin
        errs++; $display("FAIL arst_pre step=%0d got=%h want=%h", m_n, act_v, exp_v());
      end
    end
    #0.5 rst_n = 1'b0;
    #0.5;
    vecs++;
    if (act_v !== '0) begin
      errs++; $display("FAIL arst_immediate got=%h want=0", act_v);
    end
    #2.5 rst_n = 1'b1;
    model_reset();
    for (int t = 30; t < 630; t++) begin
      step(sqv(t % 100, 100, 500));
      vecs++;
      if (act_v !== exp_v()) begin
        errs++; $display("FAIL arst_post step=%0d got=%h want=%h", m_n, act_v, exp_v());
      end
    end
  endtask

  task automatic test_timeout();
    int c, ns_step;
    do_reset();
    c = 0; ns_step = -1;
    for (int p = 0; p < 6; p++)
      for (int t = 0; t < 100; t++) begin
        step(sqv(t, 100, 500));
        if (t == 0) c = m_n;
        vecs++;
        if (act_v !== exp_v()) begin
          errs++; $display("FAIL to_pre step=%0d got=%h want=%h", m_n, act_v, exp_v());
        end
      end
    for (int t = 0; t < 65540; t++) begin
      step(0);
      if (no_signal === 1'b1 && ns_step < 0) ns_step = m_n;
      vecs++;
      if (act_v !== exp_v()) begin
        errs++; $display("FAIL to_quiet step=%0d got=%h want=%h", m_n, act_v, exp_v());
      end
    end
    vecs++;
    if (ns_step != c + 65537 || stable !== 1'b0 || period !== 16'd100) begin
      errs++; $display("FAIL to_assert at=%0d want=%0d stable=%b period=%0d", ns_step, c + 65537, stable, period);
    end
    for (int p = 0; p < 6; p++)
      for (int t = 0; t < 100; t++) begin
        step(sqv(t, 100, 500));
        vecs++;
        if (act_v !== exp_v()) begin
          errs++; $display("FAIL to_resume step=%0d got=%h want=%h", m_n, act_v, exp_v());
        end
      end
  endtask

  initial begin
    test_reset();
    test_square_basic();
    test_period_change();
    test_sine_glitch();
    test_tol_boundary();
    test_random();
    test_async_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/freq_detector_hyst.md
Name: freq_detector_hyst

Overview:
Parametrised successor to the ADC-side period detector. It measures the period of a signed ADC stream in adc_clk cycles, using a Schmitt-trigger zero-crossing detector with runtime hysteresis. Periods are averaged over 2^AVG_LOG2 cycles. The block flags stability against a runtime tolerance and declares loss of signal on counter saturation. It sits directly behind the ADC capture path and feeds the measurement/display logic.

Parameters:
DATA_WIDTH, 12, width of signed ADC sample data_in
CNT_WIDTH, 16, width of period counter and period output (cycles)
AVG_LOG2, 2, log2 of number of periods averaged per result
STABLE_CYCLES, 3, consecutive matching averages required to assert stable
TOL_WIDTH, 8, width of tolerance input

Ports:
adc_clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  DATA_WIDTH  signed ADC sample, sampled every adc_clk
hyst  input  DATA_WIDTH-1  unsigned hysteresis half-width; zero-extended to signed before compare
tol  input  TOL_WIDTH  unsigned stability tolerance in cycles
period  output  CNT_WIDTH  latest averaged period (cycles)
period_valid  output  1  one-cycle pulse when period updates
stable  output  1  averaged period steady within tol
no_signal  output  1  no crossing seen for 2^CNT_WIDTH-1 cycles

Behaviour:
- Reset (async, any time, including mid-measurement): period=0, period_valid=0, stable=0, no_signal=0. Schmitt state=0, armed=0, counter=0, accumulator=0, sample count=0, match count=0, prev average=0.
- Schmitt state sch, per cycle: data_in > +hyst -> 1; data_in < -hyst -> 0; otherwise hold. Both compares are signed, DATA_WIDTH+1 bits. hyst=0 gives plain sign comparison with hold at exactly 0.
- Rising crossing: registered sch transition 0->1 gives a one-cycle internal edge pulse. Falling transitions are ignored.
- Period counter cnt: increments every cycle. On edge: sample = cnt+1, then cnt<=0. A clean input of period P yields sample=P.
- Arming: the first edge after reset or after no_signal only sets armed=1, clears no_signal and zeroes cnt. No sample is taken on that edge.
- Accumulator: width CNT_WIDTH+AVG_LOG2, no overflow possible. Each armed sample is added.
- On the 2^AVG_LOG2-th sample: period <= (sum+sample)>>AVG_LOG2 (truncating), period_valid=1 for one cycle, sum and sample count cleared.
- Latency: period/period_valid update exactly 2 adc_clk after the cycle where data_in first exceeds +hyst for the completing crossing.
- Stability, evaluated on each period_valid:
  - first average after arming: match count=0, store as prev.
  - otherwise |new - prev| <= tol -> match count+1, saturating at STABLE_CYCLES; else match count=0.
  - prev <= new in both cases.
  - stable = (match count == STABLE_CYCLES), registered, updates in the same cycle as period.
- Timeout: cnt reaching 2^CNT_WIDTH-1 without an edge forces, next cycle: no_signal=1, stable=0, armed=0, cnt=0, sum and sample count cleared, match count=0. period holds its last value. cnt then keeps running, with timeout re-asserting harmlessly.
- Simultaneous edge and timeout in the same cycle: edge wins; the sample is the saturated value 2^CNT_WIDTH-1 and no timeout occurs.
- hyst/tol changes take effect the next cycle. In-progress averages are not reset.

Test Plan:
1. Defaults, hyst=16, tol=2, square wave ±500 with period 100 -> first period_valid after arming edge + 4 periods, period=100. stable=1 on the 4th period_valid, after 1+16 rising edges.
2. Sine amplitude 500, period 400, with ±10 glitches added within 5 samples of each zero crossing -> no spurious edges; period=400. Repeat with hyst=0 -> period corrupted (<400).
3. Stable at period 100, then switch to period 200 -> the next mismatched average (e.g. 125/175) drops stable. stable re-asserts after 3 further matching averages of 200.
4. Blocks of 4 periods alternating 100/102, tol=2 -> stable asserts. Same with 100/103 -> stable stays 0.
5. Signal then constant data_in=0 -> no_signal=1 exactly 65536 cycles after the last edge, stable=0, period unchanged. Resumed square wave -> no_signal clears on first edge, next period_valid after 4 more periods.
6. rst_n low for 3 ns mid-accumulation -> all outputs 0 immediately, asynchronously. After release, the first edge only arms.
